// File: rtl/bpu_alu_pkg.sv
// Shared types for the bit-serial ALU: opcode encoding and sequencer states.
package bpu_alu_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_OR  = 2'd1,
    OP_AND = 2'd2,
    OP_NOT = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: per-bit logic results plus an MSB-first unsigned compare chain.
module alu_slice (
  input  logic a,
  input  logic b,
  input  logic prev_eq,
  input  logic prev_greater,
  output logic eq,
  output logic greater,
  output logic res_xor,
  output logic res_or,
  output logic res_and,
  output logic res_not
);

  assign res_xor = a ^ b;
  assign res_or  = a | b;
  assign res_and = a & b;
  assign res_not = ~a;

  // Higher bits decide first; a lower bit only matters while everything above was equal.
  assign eq      = prev_eq & ~(a ^ b);
  assign greater = prev_greater | (prev_eq & a & ~b);

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: walks one alu_slice over a WIDTH-bit operand pair, MSB first,
// with valid/ready handshakes on request and result.
module alu_serial_seq
  import bpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             greater
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, result_r, result_next;
  alu_op_t          op_r;
  logic             eq_r, greater_r;
  logic             s_eq, s_greater, s_xor, s_or, s_and, s_not;
  logic             sel;

  alu_slice u_slice (
    .a            (a_r[cnt]),
    .b            (b_r[cnt]),
    .prev_eq      (eq_r),
    .prev_greater (greater_r),
    .eq           (s_eq),
    .greater      (s_greater),
    .res_xor      (s_xor),
    .res_or       (s_or),
    .res_and      (s_and),
    .res_not      (s_not)
  );

  always_comb begin
    sel = 1'b0;
    unique case (op_r)
      OP_XOR: sel = s_xor;
      OP_OR:  sel = s_or;
      OP_AND: sel = s_and;
      OP_NOT: sel = s_not;
      default: sel = 1'b0;
    endcase
  end

  generate
    if (WIDTH == 1) begin : g_shift1
      assign result_next = sel;
    end else begin : g_shiftn
      assign result_next = {result_r[WIDTH-2:0], sel};
    end
  endgenerate

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_valid) state_next = RUN;
      RUN:  if (cnt == '0)   state_next = DONE;
      DONE: if (done_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_XOR;
      eq_r      <= 1'b0;
      greater_r <= 1'b0;
      result_r  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_valid) begin
          a_r       <= a;
          b_r       <= b;
          op_r      <= alu_op_t'(op);
          cnt       <= CW'(WIDTH - 1);
          eq_r      <= 1'b1;
          greater_r <= 1'b0;
          result_r  <= '0;
        end
        RUN: begin
          eq_r      <= s_eq;
          greater_r <= s_greater;
          result_r  <= result_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign result      = result_r;
  assign eq          = eq_r;
  assign greater     = greater_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq at WIDTH=8 and WIDTH=1.
module tb_alu_serial_seq;
  import bpu_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0, done_ready = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] a = '0, b = '0;
  logic       start_ready, done_valid, eq, greater;
  logic [7:0] result;

  logic       sv1 = 1'b0, dr1 = 1'b0;
  logic [1:0] op1 = 2'd0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       sr1, dv1, eq1, gt1;
  logic [0:0] res1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b), .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .eq(eq), .greater(greater)
  );

  alu_serial_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .op(op1), .a(a1), .b(b1), .done_valid(dv1), .done_ready(dr1),
    .result(res1), .eq(eq1), .greater(gt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; leaves time just after the accept edge.
  task automatic start_req(input logic [7:0] va, input logic [7:0] vb, input alu_op_t vop);
    int unsigned n = 0;
    a = va; b = vb; op = vop; start_valid = 1'b1;
    while (!start_ready && n < 20) begin tick(); n++; end
    check("start_ready_wait", 32'(start_ready), 32'd1);
    tick();
    start_valid = 1'b0;
  endtask

  // Counts edges after acceptance until done_valid; optionally scrambles inputs meanwhile.
  task automatic wait_done(input string tag, input bit scramble);
    int unsigned n = 0;
    while (!done_valid && n < 40) begin
      if (scramble) begin a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); end
      tick(); n++;
    end
    check({tag, "_latency"}, n, 32'd8);
  endtask

  task automatic check_out(input string tag, input logic [7:0] er, input logic ee, input logic eg);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_eq"}, 32'(eq), 32'(ee));
    check({tag, "_greater"}, 32'(greater), 32'(eg));
  endtask

  task automatic finish_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("idle_after_done", 32'(start_ready), 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input alu_op_t vop, input bit scramble,
                          input logic [7:0] er, input logic ee, input logic eg);
    start_req(va, vb, vop);
    check({tag, "_busy"}, 32'(start_ready), 32'd0);
    wait_done(tag, scramble);
    check_out(tag, er, ee, eg);
    finish_done();
  endtask

  initial begin
    #12;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check_out("rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    run_case("xor", 8'hA5, 8'h5A, OP_XOR, 1'b0, 8'hFF, 1'b0, 1'b1);
    run_case("and", 8'h3C, 8'h3C, OP_AND, 1'b0, 8'h3C, 1'b1, 1'b0);
    run_case("or",  8'h01, 8'h80, OP_OR,  1'b0, 8'h81, 1'b0, 1'b0);
    run_case("not", 8'h0F, 8'h0F, OP_NOT, 1'b1, 8'hF0, 1'b1, 1'b0);

    // Backpressure: result held while a new request waits.
    start_req(8'hC3, 8'h81, OP_AND);
    wait_done("bp", 1'b0);
    a = 8'h12; b = 8'h34; op = OP_OR; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_done_valid", 32'(done_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check_out("bp_hold", 8'h81, 1'b0, 1'b1);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("bp_idle", 32'(start_ready), 32'd1);
    check("bp_done_low", 32'(done_valid), 32'd0);
    tick();
    start_valid = 1'b0;
    check("bp_accepted", 32'(start_ready), 32'd0);
    wait_done("bp2", 1'b0);
    check_out("bp2", 8'h36, 1'b0, 1'b0);
    finish_done();

    // Asynchronous reset mid-RUN.
    start_req(8'hFF, 8'h00, OP_OR);
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_start_ready", 32'(start_ready), 32'd1);
    check("arst_done_valid", 32'(done_valid), 32'd0);
    check_out("arst", 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    repeat (10) begin
      tick();
      check("arst_no_done", 32'(done_valid), 32'd0);
    end
    run_case("post_rst", 8'h80, 8'h7F, OP_XOR, 1'b0, 8'hFF, 1'b0, 1'b1);

    // WIDTH=1 instance.
    a1 = 1'b1; b1 = 1'b0; op1 = OP_AND; sv1 = 1'b1;
    check("w1_ready", 32'(sr1), 32'd1);
    tick();
    sv1 = 1'b0;
    check("w1_run", 32'(dv1), 32'd0);
    tick();
    check("w1_done_valid", 32'(dv1), 32'd1);
    check("w1_result", 32'(res1), 32'd0);
    check("w1_eq", 32'(eq1), 32'd0);
    check("w1_greater", 32'(gt1), 32'd1);
    dr1 = 1'b1;
    tick();
    dr1 = 1'b0;
    check("w1_idle", 32'(sr1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that drives one `alu_slice` across a full operand word, one bit per clock, MSB first. It sits directly upstream of the slice. It latches a WIDTH-bit operand pair and opcode through a valid/ready handshake, then walks the bit index down from WIDTH-1 to 0. It chains the slice's `eq`/`greater` outputs back into `prev_eq`/`prev_greater` and shifts the selected per-bit logic result into a word register. The finished word and unsigned-compare flags are presented on a valid/ready output handshake.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start_valid`  in  1  request valid.
- `start_ready`  out  1  sequencer idle, request acceptable.
- `op`  in  2  `alu_op_t`, sampled on start handshake.
- `a`, `b`  in  WIDTH  operands, sampled on start handshake.
- `done_valid`  out  1  result, eq and greater valid.
- `done_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  logic result word.
- `eq`  out  1  a == b (unsigned, whole word).
- `greater`  out  1  a > b (unsigned, whole word).

## Operation
- States (`seq_state_t`): IDLE, RUN, DONE. `start_ready` = (state==IDLE). `done_valid` = (state==DONE). Both decode combinationally from the state register.
- IDLE + `start_valid`: latch a, b, op; bit counter ← WIDTH-1; eq_r ← 1; greater_r ← 0; result ← 0; go to RUN.
- RUN, each edge:
  - slice inputs are a_r[cnt], b_r[cnt], prev_eq=eq_r, prev_greater=greater_r;
  - eq_r ← slice eq; greater_r ← slice greater;
  - result ← {result[WIDTH-2:0], sel} (for WIDTH=1, result ← sel);
  - sel = slice xor/or/and/not output per op.
- RUN, counter: if cnt==0, go to DONE; else cnt ← cnt-1. The counter never wraps below 0.
- OP_NOT: result = ~a. b is ignored for result, but eq/greater still compare a against b.
- DONE: outputs held stable until `done_ready`. On the handshake, go to IDLE.
- No early termination: a RUN always lasts exactly WIDTH cycles, even once the compare is decided.
- `start_valid` outside IDLE is ignored. Changes on a/b/op after acceptance have no effect.
- `done_ready` outside DONE is ignored.
- Reset (any state, including mid-RUN): state IDLE, counter 0, result 0, eq_r 0, greater_r 0, latched operands 0. No `done_valid` is produced for the aborted request.
- Reset values of outputs: `start_ready`=1, `done_valid`=0, `result`=0, `eq`=0, `greater`=0.

## Timing
- Start handshake on edge E0. RUN covers edges E1..E_WIDTH. `done_valid` rises after edge E_WIDTH.
- Latency from acceptance to `done_valid` is exactly WIDTH cycles.
- DONE + `done_ready` at edge Ed gives IDLE after Ed. `start_ready` is high the cycle after the done handshake, never in the same cycle.
- Minimum back-to-back throughput: one request per WIDTH+2 cycles.
- `result`, `eq` and `greater` are registers, with no combinational path from inputs. During RUN they show partial values; consumers use them only when `done_valid` is high.

## Structure
- Shared package `bpu_alu_pkg` holds:
  - `alu_op_t` (2-bit enum: OP_XOR=0, OP_OR=1, OP_AND=2, OP_NOT=3);
  - `seq_state_t` (IDLE, RUN, DONE).
- Exactly one sub-module: a single `alu_slice` instance, purely combinational. All sequencing, muxing and registers live in `alu_serial_seq`.
- Counter width is $clog2(WIDTH), minimum 1.

## Test plan
- WIDTH=8, a=0xA5, b=0x5A, op=OP_XOR → result=0xFF, eq=0, greater=1. `done_valid` is asserted exactly 8 cycles after the start handshake.
- a=b=0x3C, op=OP_AND → result=0x3C, eq=1, greater=0. Then a=0x01, b=0x80, op=OP_OR → result=0x81, eq=0, greater=0.
- a=0x0F, b=0x0F, op=OP_NOT → result=0xF0, eq=1, greater=0. Toggling a/b during RUN does not change the outcome.
- Backpressure: hold `done_ready`=0 for 5 cycles in DONE while `start_valid`=1 → outputs stable, `start_ready`=0, no new acceptance. After `done_ready`=1: IDLE, then the new request is accepted the next cycle.
- Assert `rst_n`=0 asynchronously at RUN cycle 4 → outputs immediately read `start_ready`=1, `done_valid`=0, result=0, eq=0, greater=0. A subsequent request a=0x80, b=0x7F, OP_XOR → 0xFF, greater=1.
- WIDTH=1: a=1, b=0, OP_AND → result=0, greater=1, `done_valid` 1 cycle after acceptance.
